oldest2_issue_scheduler: RTL
============================

// Module: oldest2_issue_scheduler
// PURPOSE
//  Age-ordered, dual-issue scheduling queue for the RCU. Holds up to DEPTH in-flight uops in a circular buffer.
//  Accepts up to 2 allocations per cycle at tail and wakes up pending operands by tag broadcast.
//  Each cycle it offers the two oldest ready entries, counting from head, to issue ports 0 and 1.
//  Selection is rotating-priority oldest-2 over the valid&ready vector, with the head index as priority.
// PARAMETERS
//  DEPTH          8   number of entries; must be a power of 2, >= 4
//  PTR_WIDTH      3   log2(DEPTH); head/tail pointers carry one extra wrap bit
//  TAG_WIDTH      6   physical-register tag width used for wakeup match
//  PAYLOAD_WIDTH  32  opaque uop payload carried to the issue ports
// PORTS
//  clk               in   1              clock, rising edge
//  rstn              in   1              asynchronous active-low reset
//  flush_i           in   1              synchronous flush of all entries
//  alloc0_valid_i    in   1              allocate slot 0; alloc1_valid_i is legal only when this is 1
//  alloc0_payload_i  in   PAYLOAD_WIDTH  payload for slot 0
//  alloc0_tag_i      in   TAG_WIDTH      pending source tag for slot 0
//  alloc0_rdy_i      in   1              source already ready for slot 0
//  alloc1_valid_i    in   1              allocate slot 1, younger than slot 0
//  alloc1_payload_i  in   PAYLOAD_WIDTH  payload for slot 1
//  alloc1_tag_i      in   TAG_WIDTH      pending source tag for slot 1
//  alloc1_rdy_i      in   1              source already ready for slot 1
//  alloc_ready_o     out  1              at least 2 free entries
//  wake0_valid_i     in   1              wakeup broadcast 0 valid
//  wake0_tag_i       in   TAG_WIDTH      wakeup broadcast 0 tag
//  wake1_valid_i     in   1              wakeup broadcast 1 valid
//  wake1_tag_i       in   TAG_WIDTH      wakeup broadcast 1 tag
//  issue0_valid_o    out  1              oldest ready entry offered
//  issue0_payload_o  out  PAYLOAD_WIDTH  payload of the oldest ready entry
//  issue0_ready_i    in   1              issue port 0 accepts
//  issue1_valid_o    out  1              second-oldest ready entry offered
//  issue1_payload_o  out  PAYLOAD_WIDTH  payload of the second-oldest ready entry
//  issue1_ready_i    in   1              issue port 1 accepts
//  empty_o           out  1              no entries are occupied between head and tail
//  count_o           out  PTR_WIDTH+1    occupied slots, including issued holes not yet retired by head
// BEHAVIOUR
//  - Reset (rstn=0, async): all entry valid/ready=0; head=tail=0 with wrap bit 0.
//    Outputs at reset: alloc_ready_o=1, issue*_valid_o=0, empty_o=1, count_o=0.
//  - Occupancy: count = tail - head over PTR_WIDTH+1 bits. empty when pointers are equal incl. wrap bit.
//    full when index bits are equal and wrap bits differ. alloc_ready_o = (DEPTH - count >= 2).
//  - Allocation: fires when allocN_valid_i && alloc_ready_o. Slot 0 is written at tail, slot 1 at tail+1.
//    tail advances by 1 or 2, wrapping modulo DEPTH and toggling the wrap bit.
//    Allocation while alloc_ready_o=0 is ignored: no write, no pointer move.
//  - Entry ready at write = allocN_rdy_i | (wakeK_valid_i && wakeK_tag_i == allocN_tag_i) for any K.
//    This is a same-cycle wakeup bypass into allocation.
//  - Wakeup: every valid, not-ready entry whose tag matches a valid wake tag sets ready at the next edge.
//  - Select is combinational on registered state; there is no bypass from same-cycle wakeup to issue.
//    req = valid & ready. Priority starts at the head index and wraps.
//    issue0 = first set bit of req; issue1 = second set bit of req.
//    Minimum latency from allocation with rdy=1 (or from a matching wakeup) to issue*_valid_o is 1 cycle.
//  - Issue handshake: ports are independent. Port N fires when issueN_valid_o && issueN_ready_i.
//    The fired entry is cleared (valid=0) at the next edge. issue1 may fire while issue0 stalls.
//    issue*_valid_o and payload are not held stable across cycles; selection re-evaluates every cycle.
//  - Head retire: head advances over invalid (issued) entries contiguous from head, at most 2 per cycle.
//    head never passes tail. Holes behind a still-valid older entry remain counted until head passes them.
//  - Simultaneous alloc + issue + retire in one cycle are all legal.
//    Allocation uses the pre-update free count, so space freed this cycle is visible next cycle.
//  - flush_i (priority over everything): next edge clears all entries and sets head=tail=0.
//    issue*_valid_o are still driven combinationally in the flush cycle, but an issue fire is not honoured.
//    Allocation in the flush cycle is dropped.
//  - Reset asserted mid-operation: immediate return to the reset state regardless of in-flight handshakes.
// TESTING
//  1. Reset: rstn=0 -> alloc_ready_o=1, empty_o=1, count_o=0, issue0/1_valid_o=0.
//  2. Allocate A (rdy=1) and B (rdy=1) in one cycle with both issue ports ready.
//     -> next cycle issue0=A, issue1=B; after that count_o=0, empty_o=1.
//  3. Allocate 8 not-ready entries with tags 0..7 -> alloc_ready_o=0 at count 7 and 8; a 9th allocation is ignored.
//     Then wake tag 5 -> only entry 5 issues, on port 0.
//  4. Wrap/age ordering: head=6 with entries at idx 6,7,0,1; make idx 1 and 7 ready.
//     -> issue0=idx7, issue1=idx1 (age order, not index order).
//  5. Same-cycle wakeup bypass: allocate tag 9 with rdy=0 while wake1 tag=9.
//     -> entry is ready next cycle and issue0_valid_o=1 one cycle after allocation.
//  6. Flush with 4 valid entries and issue0_ready_i=1 -> next cycle empty_o=1, count_o=0,
//     and no entry is recorded as issued.

Source files
------------

// File: rtl/oldest2_issue_scheduler_if.sv
// Allocation, wakeup, issue and status signals of the oldest-2 issue scheduler.
// master drives allocation/wakeup/issue-ready; slave is the scheduler.
interface oldest2_issue_scheduler_if #(
   parameter int unsigned PTR_WIDTH     = 3,
   parameter int unsigned TAG_WIDTH     = 6,
   parameter int unsigned PAYLOAD_WIDTH = 32
);
   logic                     flush_i;
   logic                     alloc0_valid_i;
   logic [PAYLOAD_WIDTH-1:0] alloc0_payload_i;
   logic [TAG_WIDTH-1:0]     alloc0_tag_i;
   logic                     alloc0_rdy_i;
   logic                     alloc1_valid_i;
   logic [PAYLOAD_WIDTH-1:0] alloc1_payload_i;
   logic [TAG_WIDTH-1:0]     alloc1_tag_i;
   logic                     alloc1_rdy_i;
   logic                     alloc_ready_o;
   logic                     wake0_valid_i;
   logic [TAG_WIDTH-1:0]     wake0_tag_i;
   logic                     wake1_valid_i;
   logic [TAG_WIDTH-1:0]     wake1_tag_i;
   logic                     issue0_valid_o;
   logic [PAYLOAD_WIDTH-1:0] issue0_payload_o;
   logic                     issue0_ready_i;
   logic                     issue1_valid_o;
   logic [PAYLOAD_WIDTH-1:0] issue1_payload_o;
   logic                     issue1_ready_i;
   logic                     empty_o;
   logic [PTR_WIDTH:0]       count_o;

   modport master (
      output flush_i, alloc0_valid_i, alloc0_payload_i, alloc0_tag_i, alloc0_rdy_i,
             alloc1_valid_i, alloc1_payload_i, alloc1_tag_i, alloc1_rdy_i,
             wake0_valid_i, wake0_tag_i, wake1_valid_i, wake1_tag_i,
             issue0_ready_i, issue1_ready_i,
      input  alloc_ready_o, issue0_valid_o, issue0_payload_o, issue1_valid_o,
             issue1_payload_o, empty_o, count_o
   );

   modport slave (
      input  flush_i, alloc0_valid_i, alloc0_payload_i, alloc0_tag_i, alloc0_rdy_i,
             alloc1_valid_i, alloc1_payload_i, alloc1_tag_i, alloc1_rdy_i,
             wake0_valid_i, wake0_tag_i, wake1_valid_i, wake1_tag_i,
             issue0_ready_i, issue1_ready_i,
      output alloc_ready_o, issue0_valid_o, issue0_payload_o, issue1_valid_o,
             issue1_payload_o, empty_o, count_o
   );
endinterface

// File: rtl/oldest2_issue_scheduler.sv
// Age-ordered dual-issue scheduling queue: circular buffer, dual allocate at tail,
// tag wakeup, and rotating-priority oldest-2 select starting at head.
module oldest2_issue_scheduler #(
   parameter int unsigned DEPTH         = 8,
   parameter int unsigned PTR_WIDTH     = 3,
   parameter int unsigned TAG_WIDTH     = 6,
   parameter int unsigned PAYLOAD_WIDTH = 32
) (
   input logic                      clk,
   input logic                      rstn,
   oldest2_issue_scheduler_if.slave bus
);
   typedef logic [PTR_WIDTH:0]   ptr_t;
   typedef logic [PTR_WIDTH-1:0] idx_t;

   logic [DEPTH-1:0]         valid_q, valid_d, ready_q, ready_d, wake_set;
   logic [TAG_WIDTH-1:0]     tag_q     [DEPTH];
   logic [PAYLOAD_WIDTH-1:0] payload_q [DEPTH];
   ptr_t                     head_q, head_d, tail_q, tail_d;

   function automatic logic wake_hit(input logic [TAG_WIDTH-1:0] tag,
                                     input logic v0, input logic [TAG_WIDTH-1:0] t0,
                                     input logic v1, input logic [TAG_WIDTH-1:0] t1);
      return (v0 && (t0 == tag)) || (v1 && (t1 == tag));
   endfunction

   ptr_t count;
   logic alloc_ready;
   idx_t head_idx, head_idx1, tail_idx, tail_idx1;

   assign count       = tail_q - head_q;
   assign alloc_ready = count <= ptr_t'(DEPTH - 2);
   assign head_idx    = head_q[PTR_WIDTH-1:0];
   assign head_idx1   = head_idx + idx_t'(1);
   assign tail_idx    = tail_q[PTR_WIDTH-1:0];
   assign tail_idx1   = tail_idx + idx_t'(1);

   // Rotating-priority scan: first two valid&ready entries in age order from head.
   idx_t sel0, sel1, scan;
   logic found0, found1;
   always_comb begin
      sel0   = '0;
      sel1   = '0;
      found0 = 1'b0;
      found1 = 1'b0;
      scan   = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         scan = head_idx + idx_t'(i);
         if (valid_q[scan] && ready_q[scan]) begin
            if (!found0) begin
               found0 = 1'b1;
               sel0   = scan;
            end else if (!found1) begin
               found1 = 1'b1;
               sel1   = scan;
            end
         end
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_wake
      assign wake_set[g] = valid_q[g] && !ready_q[g] &&
                           wake_hit(tag_q[g], bus.wake0_valid_i, bus.wake0_tag_i,
                                    bus.wake1_valid_i, bus.wake1_tag_i);
   end

   logic alloc0_fire, alloc1_fire, issue0_fire, issue1_fire, retire0, retire1;
   logic alloc0_rdy, alloc1_rdy;
   assign alloc0_fire = bus.alloc0_valid_i && alloc_ready;
   assign alloc1_fire = alloc0_fire && bus.alloc1_valid_i;
   assign issue0_fire = found0 && bus.issue0_ready_i;
   assign issue1_fire = found1 && bus.issue1_ready_i;
   assign alloc0_rdy  = bus.alloc0_rdy_i ||
                        wake_hit(bus.alloc0_tag_i, bus.wake0_valid_i, bus.wake0_tag_i,
                                 bus.wake1_valid_i, bus.wake1_tag_i);
   assign alloc1_rdy  = bus.alloc1_rdy_i ||
                        wake_hit(bus.alloc1_tag_i, bus.wake0_valid_i, bus.wake0_tag_i,
                                 bus.wake1_valid_i, bus.wake1_tag_i);
   // Retire only holes already cleared in registered state, never past tail.
   assign retire0 = (head_q != tail_q) && !valid_q[head_idx];
   assign retire1 = retire0 && ((head_q + ptr_t'(1)) != tail_q) && !valid_q[head_idx1];

   always_comb begin
      valid_d = valid_q;
      ready_d = ready_q | wake_set;
      head_d  = head_q + (retire1 ? ptr_t'(2) : retire0 ? ptr_t'(1) : ptr_t'(0));
      tail_d  = tail_q + (alloc1_fire ? ptr_t'(2) : alloc0_fire ? ptr_t'(1) : ptr_t'(0));
      if (issue0_fire) begin
         valid_d[sel0] = 1'b0;
         ready_d[sel0] = 1'b0;
      end
      if (issue1_fire) begin
         valid_d[sel1] = 1'b0;
         ready_d[sel1] = 1'b0;
      end
      if (alloc0_fire) begin
         valid_d[tail_idx] = 1'b1;
         ready_d[tail_idx] = alloc0_rdy;
      end
      if (alloc1_fire) begin
         valid_d[tail_idx1] = 1'b1;
         ready_d[tail_idx1] = alloc1_rdy;
      end
      if (bus.flush_i) begin
         valid_d = '0;
         ready_d = '0;
         head_d  = '0;
         tail_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_q <= '0;
         ready_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         valid_q <= valid_d;
         ready_q <= ready_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   // Tag/payload storage needs no reset; valid_q gates every use.
   always_ff @(posedge clk) begin
      if (alloc0_fire) begin
         tag_q[tail_idx]     <= bus.alloc0_tag_i;
         payload_q[tail_idx] <= bus.alloc0_payload_i;
      end
      if (alloc1_fire) begin
         tag_q[tail_idx1]     <= bus.alloc1_tag_i;
         payload_q[tail_idx1] <= bus.alloc1_payload_i;
      end
   end

   assign bus.alloc_ready_o    = alloc_ready;
   assign bus.issue0_valid_o   = found0;
   assign bus.issue0_payload_o = payload_q[sel0];
   assign bus.issue1_valid_o   = found1;
   assign bus.issue1_payload_o = payload_q[sel1];
   assign bus.empty_o          = head_q == tail_q;
   assign bus.count_o          = count;
endmodule
